vga_timing_gen: RTL and testbench

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

---
 rtl/vga_pkg.sv | 27 ++
 rtl/vga_sync_delay.sv | 31 +++
 rtl/vga_timing_gen.sv | 112 +++++++++++
 tb/tb_vga_timing_gen.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared VGA timing constants (640x480@60) and helpers for the video pipeline.
package vga_pkg;

  localparam int unsigned VgaHActive = 640;
  localparam int unsigned VgaHFp     = 16;
  localparam int unsigned VgaHSync   = 96;
  localparam int unsigned VgaHBp     = 48;
  localparam int unsigned VgaVActive = 480;
  localparam int unsigned VgaVFp     = 10;
  localparam int unsigned VgaVSync   = 2;
  localparam int unsigned VgaVBp     = 33;

  // Both syncs are active-low in the 640x480@60 mode.
  localparam logic SyncActiveLow = 1'b0;

  typedef struct packed {
    logic video_on;
    logic v_sync;
    logic h_sync;
  } sync_t;

  function automatic logic in_window(input int unsigned pos, input int unsigned lo,
                                     input int unsigned len);
    return (pos >= lo) && (pos < lo + len);
  endfunction

endpackage

// File: rtl/vga_sync_delay.sv
// Enabled shift line for the 3-bit sync/video bundle; taps reset to inactive levels.
module vga_sync_delay #(
  parameter int unsigned Depth    = 2,
  parameter logic [2:0]  ResetVal = 3'b011
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       en_i,
  input  logic [2:0] d_i,
  output logic [2:0] q_o
);

  if (Depth == 0) begin : g_comb
    // No taps: keep reset behaviour consistent with the registered case.
    assign q_o = rst_ni ? d_i : ResetVal;
  end else begin : g_taps
    logic [2:0] tap_q [Depth];

    always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
        for (int i = 0; i < int'(Depth); i++) tap_q[i] <= ResetVal;
      end else if (en_i) begin
        tap_q[0] <= d_i;
        for (int i = 1; i < int'(Depth); i++) tap_q[i] <= tap_q[i-1];
      end
    end

    assign q_o = tap_q[Depth-1];
  end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster counters, delayed sync/video flags, line/frame pulses and a
// frame-buffer swap handshake granted at the first pixel of vertical blanking.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int unsigned H_ACTIVE = VgaHActive,
  parameter int unsigned H_FP     = VgaHFp,
  parameter int unsigned H_SYNC   = VgaHSync,
  parameter int unsigned H_BP     = VgaHBp,
  parameter int unsigned V_ACTIVE = VgaVActive,
  parameter int unsigned V_FP     = VgaVFp,
  parameter int unsigned V_SYNC   = VgaVSync,
  parameter int unsigned V_BP     = VgaVBp,
  parameter logic        HS_POL   = SyncActiveLow,
  parameter logic        VS_POL   = SyncActiveLow,
  parameter int unsigned PIPE_DLY = 2,
  parameter int unsigned CW       = 10
) (
  input  logic          pixel_clk,
  input  logic          reset,
  input  logic          pix_en,
  input  logic          swap_req,
  output logic          h_sync,
  output logic          v_sync,
  output logic          video_on,
  output logic [CW-1:0] pixel_x,
  output logic [CW-1:0] pixel_y,
  output logic          line_over,
  output logic          frame_over,
  output logic          swap_ack
);

  localparam int unsigned HTotal = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned VTotal = V_ACTIVE + V_FP + V_SYNC + V_BP;

  if (HTotal > (1 << CW) || VTotal > (1 << CW) || PIPE_DLY > 4) begin : g_bad_params
    $error("vga_timing_gen: totals exceed counter width or PIPE_DLY > 4");
  end

  localparam logic [CW-1:0] HLast  = CW'(HTotal - 1);
  localparam logic [CW-1:0] VLast  = CW'(VTotal - 1);
  localparam logic [CW-1:0] VGrant = CW'(V_ACTIVE);

  logic [CW-1:0] x_q, x_d, y_q, y_d;
  logic          pending_q, pending_d;
  logic          line_end, frame_end, grant;
  sync_t         raw, dly;

  assign line_end  = (x_q == HLast);
  assign frame_end = line_end && (y_q == VLast);

  // A request arriving in the grant tick itself is served immediately.
  assign grant = pix_en && reset && (x_q == '0) && (y_q == VGrant) && (pending_q || swap_req);

  always_comb begin
    x_d       = x_q;
    y_d       = y_q;
    pending_d = pending_q;
    if (pix_en) begin
      if (line_end) begin
        x_d = '0;
        y_d = (y_q == VLast) ? '0 : y_q + 1'b1;
      end else begin
        x_d = x_q + 1'b1;
      end
    end
    if (grant) begin
      pending_d = 1'b0;
    end else if (swap_req) begin
      pending_d = 1'b1;
    end
  end

  always_ff @(posedge pixel_clk) begin
    if (!reset) begin
      x_q       <= '0;
      y_q       <= '0;
      pending_q <= 1'b0;
    end else begin
      x_q       <= x_d;
      y_q       <= y_d;
      pending_q <= pending_d;
    end
  end

  always_comb begin
    raw.h_sync   = in_window(32'(x_q), H_ACTIVE + H_FP, H_SYNC) ? HS_POL : ~HS_POL;
    raw.v_sync   = in_window(32'(y_q), V_ACTIVE + V_FP, V_SYNC) ? VS_POL : ~VS_POL;
    raw.video_on = (32'(x_q) < H_ACTIVE) && (32'(y_q) < V_ACTIVE);
  end

  vga_sync_delay #(
    .Depth    (PIPE_DLY),
    .ResetVal ({1'b0, ~VS_POL, ~HS_POL})
  ) u_sync_delay (
    .clk_i  (pixel_clk),
    .rst_ni (reset),
    .en_i   (pix_en),
    .d_i    (raw),
    .q_o    (dly)
  );

  assign h_sync     = dly.h_sync;
  assign v_sync     = dly.v_sync;
  assign video_on   = dly.video_on;
  assign pixel_x    = x_q;
  assign pixel_y    = y_q;
  assign line_over  = pix_en && reset && line_end;
  assign frame_over = pix_en && reset && frame_end;
  assign swap_ack   = grant;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: default-size instance for line timing, small instance for frame/swap timing.
module tb_vga_timing_gen;

  logic pixel_clk = 1'b0;
  logic rst_n     = 1'b0;
  logic pix_en    = 1'b0;
  logic swap_req  = 1'b0;

  always #5 pixel_clk = ~pixel_clk;

  logic       h_sync, v_sync, video_on, line_over, frame_over, swap_ack;
  logic [9:0] pixel_x, pixel_y;

  vga_timing_gen dut (
    .pixel_clk  (pixel_clk),
    .reset      (rst_n),
    .pix_en     (pix_en),
    .swap_req   (swap_req),
    .h_sync     (h_sync),
    .v_sync     (v_sync),
    .video_on   (video_on),
    .pixel_x    (pixel_x),
    .pixel_y    (pixel_y),
    .line_over  (line_over),
    .frame_over (frame_over),
    .swap_ack   (swap_ack)
  );

  // Small raster: H_TOTAL=25 (sync x 18..21), V_TOTAL=19 (sync y 14..15), frame = 475 ticks.
  logic       s_h_sync, s_v_sync, s_video_on, s_line_over, s_frame_over, s_swap_ack;
  logic [5:0] s_pixel_x, s_pixel_y;

  vga_timing_gen #(
    .H_ACTIVE (16), .H_FP (2), .H_SYNC (4), .H_BP (3),
    .V_ACTIVE (12), .V_FP (2), .V_SYNC (2), .V_BP (3),
    .HS_POL   (1'b0), .VS_POL (1'b0), .PIPE_DLY (2), .CW (6)
  ) dut_s (
    .pixel_clk  (pixel_clk),
    .reset      (rst_n),
    .pix_en     (pix_en),
    .swap_req   (swap_req),
    .h_sync     (s_h_sync),
    .v_sync     (s_v_sync),
    .video_on   (s_video_on),
    .pixel_x    (s_pixel_x),
    .pixel_y    (s_pixel_y),
    .line_over  (s_line_over),
    .frame_over (s_frame_over),
    .swap_ack   (s_swap_ack)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Drive inputs at the falling edge; outputs are then observed before the next rising edge.
  task automatic cyc(input logic rst, input logic en, input logic sr);
    @(negedge pixel_clk);
    rst_n    = rst;
    pix_en   = en;
    swap_req = sr;
    #1;
  endtask

  int   lo_bad, lo_n, lo_c0, lo_c1, hs_low, t;
  logic hs_a, hs_b, hs_c, hs_d, vo_a, vo_b;
  int   fo_n, fo_k0, fo_k1, vs_low, slo_n, ack_n, ack_k;
  logic fo_lo, vs_a, vs_b, vs_c, vs_d, svo_a, svo_b;
  logic [5:0] fo_x, fo_y;

  initial begin
    // Reset held with pix_en=1.
    repeat (5) cyc(1'b0, 1'b1, 1'b0);
    check_eq("rst_pixel_x", 32'(pixel_x), 0);
    check_eq("rst_pixel_y", 32'(pixel_y), 0);
    check_eq("rst_h_sync", 32'(h_sync), 1);
    check_eq("rst_v_sync", 32'(v_sync), 1);
    check_eq("rst_video_on", 32'(video_on), 0);
    check_eq("rst_line_over", 32'(line_over), 0);
    check_eq("rst_frame_over", 32'(frame_over), 0);
    check_eq("rst_swap_ack", 32'(swap_ack), 0);

    // Default timing, pix_en every second cycle.
    lo_bad = 0; lo_n = 0; lo_c0 = 0; lo_c1 = 0; hs_low = 0;
    for (int c = 0; c < 3400; c++) begin
      cyc(1'b1, (c % 2) == 0, 1'b0);
      if (line_over) begin
        if (!pix_en) lo_bad++;
        else begin
          if (lo_n == 0) lo_c0 = c;
          else if (lo_n == 1) lo_c1 = c;
          lo_n++;
        end
      end
      if (pix_en) begin
        t = c / 2;
        if (t < 800 && !h_sync) hs_low++;
        if (t == 657) hs_a = h_sync;
        if (t == 658) hs_b = h_sync;
        if (t == 753) hs_c = h_sync;
        if (t == 754) hs_d = h_sync;
        if (t == 641) vo_a = video_on;
        if (t == 642) vo_b = video_on;
      end
    end
    check_eq("lo_without_en", lo_bad, 0);
    check_eq("lo_count", lo_n, 2);
    check_eq("lo_first_cycle", lo_c0, 1598);
    check_eq("lo_period", lo_c1 - lo_c0, 1600);
    check_eq("hs_low_ticks", hs_low, 96);
    check_eq("hs_x657", 32'(hs_a), 1);
    check_eq("hs_x658", 32'(hs_b), 0);
    check_eq("hs_x753", 32'(hs_c), 0);
    check_eq("hs_x754", 32'(hs_d), 1);
    check_eq("vo_x641", 32'(vo_a), 1);
    check_eq("vo_x642", 32'(vo_b), 0);
    check_eq("hold_pixel_x", 32'(pixel_x), 100);
    check_eq("hold_pixel_y", 32'(pixel_y), 2);

    // Small raster, continuous pix_en: frame pulses and vertical sync.
    repeat (2) cyc(1'b0, 1'b1, 1'b0);
    fo_n = 0; fo_k0 = 0; fo_k1 = 0; vs_low = 0; slo_n = 0;
    for (int k = 0; k < 1000; k++) begin
      cyc(1'b1, 1'b1, 1'b0);
      if (s_frame_over) begin
        if (fo_n == 0) begin
          fo_k0 = k; fo_lo = s_line_over; fo_x = s_pixel_x; fo_y = s_pixel_y;
        end else if (fo_n == 1) fo_k1 = k;
        fo_n++;
      end
      if (k < 475 && s_line_over) slo_n++;
      if (k < 475 && !s_v_sync) vs_low++;
      if (k == 351) vs_a = s_v_sync;
      if (k == 352) vs_b = s_v_sync;
      if (k == 401) vs_c = s_v_sync;
      if (k == 402) vs_d = s_v_sync;
      if (k == 17) svo_a = s_video_on;
      if (k == 18) svo_b = s_video_on;
    end
    check_eq("fo_count", fo_n, 2);
    check_eq("fo_first", fo_k0, 474);
    check_eq("fo_second", fo_k1, 949);
    check_eq("fo_with_lo", 32'(fo_lo), 1);
    check_eq("fo_x", 32'(fo_x), 24);
    check_eq("fo_y", 32'(fo_y), 18);
    check_eq("s_lo_per_frame", slo_n, 19);
    check_eq("vs_low_ticks", vs_low, 50);
    check_eq("vs_y14_x1", 32'(vs_a), 1);
    check_eq("vs_y14_x2", 32'(vs_b), 0);
    check_eq("vs_y16_x1", 32'(vs_c), 0);
    check_eq("vs_y16_x2", 32'(vs_d), 1);
    check_eq("s_vo_x17", 32'(svo_a), 1);
    check_eq("s_vo_x18", 32'(svo_b), 0);

    // Two requests in one frame merge into a single grant at (0,12).
    repeat (2) cyc(1'b0, 1'b1, 1'b0);
    ack_n = 0; ack_k = -1;
    for (int k = 0; k < 1000; k++) begin
      cyc(1'b1, 1'b1, (k == 80) || (k == 157));
      if (s_swap_ack) begin ack_n++; ack_k = k; end
    end
    check_eq("merge_ack_count", ack_n, 1);
    check_eq("merge_ack_tick", ack_k, 300);

    // Request exactly in the grant tick is consumed there.
    repeat (2) cyc(1'b0, 1'b1, 1'b0);
    ack_n = 0; ack_k = -1;
    for (int k = 0; k < 1000; k++) begin
      cyc(1'b1, 1'b1, k == 300);
      if (s_swap_ack) begin ack_n++; ack_k = k; end
    end
    check_eq("same_tick_ack_count", ack_n, 1);
    check_eq("same_tick_ack_tick", ack_k, 300);

    // Reset mid-frame with a request pending.
    repeat (2) cyc(1'b0, 1'b1, 1'b0);
    ack_n = 0;
    for (int k = 0; k < 199; k++) begin
      cyc(1'b1, 1'b1, k == 125);
      if (s_swap_ack) ack_n++;
    end
    cyc(1'b0, 1'b1, 1'b0);
    check_eq("rst_gates_line_over", 32'(s_line_over), 0);
    repeat (2) cyc(1'b0, 1'b1, 1'b0);
    check_eq("mid_rst_pixel_x", 32'(s_pixel_x), 0);
    check_eq("mid_rst_pixel_y", 32'(s_pixel_y), 0);
    check_eq("mid_rst_h_sync", 32'(s_h_sync), 1);
    check_eq("mid_rst_v_sync", 32'(s_v_sync), 1);
    check_eq("mid_rst_video_on", 32'(s_video_on), 0);
    check_eq("mid_rst_pulses", 32'({s_line_over, s_frame_over, s_swap_ack}), 0);
    for (int k = 0; k < 1000; k++) begin
      cyc(1'b1, 1'b1, 1'b0);
      if (s_swap_ack) ack_n++;
      if (k == 0) begin
        check_eq("restart_x0", 32'(s_pixel_x), 0);
        check_eq("restart_vo0", 32'(s_video_on), 0);
      end
      if (k == 1) check_eq("restart_x1", 32'(s_pixel_x), 1);
    end
    check_eq("discarded_ack_count", ack_n, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
